// File: rtl/delay_pkg.sv
// Shared types and defaults for the delay-path latency detector.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEF       = 2;
  localparam int MAX_LAT_DEF = 15;
  localparam int EXP_LAT_DEF = 2;

  // A MAX_LAT of 0 would otherwise give a zero-width latency bus.
  function automatic int lat_width(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/delay_lat_detect_chg_det.sv
// Change detector: registers a W-bit stream and flags a cycle where it differs from last cycle.
module chg_det #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         evt
);

  logic [W-1:0] r_q;

  // Previous-cycle copy of the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= d;
    end
  end

  assign q   = r_q;
  assign evt = (d != r_q);

endmodule

// File: rtl/delay_lat_detect.sv
// Measures cycles between a source-stream change and the same value appearing on the delayed stream.
// Optional macro DLY_DET_CHECK_EN adds a mismatch output comparing the result against EXP_LAT.
module delay_lat_detect
  import delay_pkg::*;
#(
  parameter int  W       = W_DEF,
  parameter int  MAX_LAT = MAX_LAT_DEF,
  parameter int  EXP_LAT = EXP_LAT_DEF,
  localparam int LW      = lat_width(MAX_LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_src,
  input  logic [W-1:0]  data_dly,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [LW-1:0] lat
`ifdef DLY_DET_CHECK_EN
  ,
  output logic          mismatch
`endif
);

  state_t        r_state;
  logic [LW-1:0] r_cnt;
  logic [W-1:0]  r_mark;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [LW-1:0] r_lat;
  logic          r_mismatch;

  logic [W-1:0]  w_src_q;
  logic [W-1:0]  w_dly_q;
  logic          w_src_evt;
  logic          w_dly_evt;
  logic          w_unused;

  chg_det #(.W(W)) u_src_det (
    .clk (clk),
    .rst (rst),
    .d   (data_src),
    .q   (w_src_q),
    .evt (w_src_evt)
  );

  chg_det #(.W(W)) u_dly_det (
    .clk (clk),
    .rst (rst),
    .d   (data_dly),
    .q   (w_dly_q),
    .evt (w_dly_evt)
  );

  assign w_unused = ^{w_src_q, w_dly_q, EXP_LAT[0]};

  // Measurement FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_mark     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_lat      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          if (w_src_evt) begin
            r_mark <= data_src;
            if (w_dly_evt && (data_dly == data_src)) begin
              r_lat      <= '0;
              r_timeout  <= 1'b0;
              r_mismatch <= (EXP_LAT != 0);
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cnt   <= LW'(1);
              r_state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (w_dly_evt && (data_dly == r_mark)) begin
            r_lat      <= r_cnt;
            r_timeout  <= 1'b0;
            r_mismatch <= (int'(r_cnt) != EXP_LAT);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else if (r_cnt == LW'(MAX_LAT)) begin
            r_lat      <= LW'(MAX_LAT);
            r_timeout  <= 1'b1;
            r_mismatch <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_timeout;
  assign lat     = r_lat;
`ifdef DLY_DET_CHECK_EN
  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_delay_lat_detect.sv
// Directed self-checking bench for delay_lat_detect; the delay path is modelled with a 3-stage register chain.
module tb_delay_lat_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] data_src;
  logic [1:0] data_dly;
  logic [1:0] d1, d2, d3;
  logic [1:0] tie;
  int         dly_sel;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [3:0] lat;
`ifdef DLY_DET_CHECK_EN
  logic       mismatch;
`endif

  int n_pass  = 0;
  int n_total = 0;

  delay_lat_detect dut (
    .clk      (clk),
    .rst      (rst),
    .data_src (data_src),
    .data_dly (data_dly),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .lat      (lat)
`ifdef DLY_DET_CHECK_EN
    ,
    .mismatch (mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Delay path under test.
  always_ff @(posedge clk) begin
    d1 <= data_src;
    d2 <= d1;
    d3 <= d2;
  end

  always_comb begin
    case (dly_sel)
      0:       data_dly = data_src;
      2:       data_dly = d2;
      3:       data_dly = d3;
      default: data_dly = tie;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nd;
    rst      = 1'b1;
    start    = 1'b0;
    data_src = 2'b10;
    tie      = 2'b00;
    dly_sel  = 3;
    cycle(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lat", lat, 0);
    chk("rst_timeout", timeout, 0);
`ifdef DLY_DET_CHECK_EN
    chk("rst_mismatch", mismatch, 0);
`endif
    rst = 1'b0;
    cycle(4);

    // 3-register path
    start_pulse();
    chk("arm_busy", busy, 1);
    data_src = 2'b01;
    wait_done(n);
    chk("d3_cycles", n, 4);
    chk("d3_lat", lat, 3);
    chk("d3_timeout", timeout, 0);
    chk("d3_busy", busy, 0);
`ifdef DLY_DET_CHECK_EN
    chk("d3_mismatch", mismatch, 1);
`endif
    cycle(1);
    chk("d3_done_one_cycle", done, 0);
    chk("d3_lat_hold", lat, 3);

    // 2-register path
    dly_sel = 2;
    cycle(3);
    start_pulse();
    data_src = 2'b10;
    wait_done(n);
    chk("d2_cycles", n, 3);
    chk("d2_lat", lat, 2);
    chk("d2_timeout", timeout, 0);
`ifdef DLY_DET_CHECK_EN
    chk("d2_mismatch", mismatch, 0);
`endif

    // delayed stream stuck: timeout
    dly_sel  = 4;
    data_src = 2'b00;
    cycle(4);
    start_pulse();
    data_src = 2'b11;
    wait_done(n);
    chk("to_cycles", n, 16);
    chk("to_timeout", timeout, 1);
    chk("to_lat", lat, 15);
`ifdef DLY_DET_CHECK_EN
    chk("to_mismatch", mismatch, 1);
`endif
    cycle(1);
    chk("to_timeout_hold", timeout, 1);
    chk("to_done_low", done, 0);

    // zero-delay path
    dly_sel  = 0;
    data_src = 2'b01;
    cycle(3);
    start_pulse();
    data_src = 2'b11;
    wait_done(n);
    chk("d0_cycles", n, 1);
    chk("d0_lat", lat, 0);
    chk("d0_timeout", timeout, 0);
`ifdef DLY_DET_CHECK_EN
    chk("d0_mismatch", mismatch, 1);
`endif

    // reset while counting (cnt=2)
    dly_sel  = 3;
    data_src = 2'b00;
    cycle(4);
    start_pulse();
    data_src = 2'b10;
    cycle(2);
    rst = 1'b1;
    cycle(1);
    chk("abort_busy", busy, 0);
    chk("abort_lat", lat, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    count_done(8, nd);
    chk("abort_no_done", nd, 0);
    start_pulse();
    data_src = 2'b01;
    wait_done(n);
    chk("fresh_cycles", n, 4);
    chk("fresh_lat", lat, 3);

    // start repeated during COUNT is ignored
    cycle(3);
    start_pulse();
    data_src = 2'b10;
    cycle(1);
    start_pulse();
    wait_done(n);
    chk("restart_cycles", n, 2);
    chk("restart_lat", lat, 3);
    count_done(8, nd);
    chk("restart_single_done", nd, 0);
    chk("restart_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
